data_cache_ctrl: RTL

//  Responder end of the pipeline's data-memory request handshake.
//  - MEM stage issues is_input_valid/addr/mem_read/mem_write/din.
//  - Block answers with is_ready/is_output_valid/dout/is_hit.
//  - Direct-mapped, write-back, write-allocate data cache.
//  - Sits between the MEM stage and a multi-cycle line-wide backing memory.

---
 rtl/cache_pkg.sv | 22 ++
 rtl/cache_line_store.sv | 43 ++++
 rtl/data_cache_ctrl.sv | 83 ++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// cache_pkg: geometry, FSM states and address field helpers shared by the data cache.
package cache_pkg;
  localparam int LINE_BYTES = 16;
  localparam int NUM_SETS = 16;
  localparam int ADDR_W = 32;
  localparam int OFFSET_W = $clog2(LINE_BYTES);
  localparam int INDEX_W = $clog2(NUM_SETS);
  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int WORD_SEL_W = OFFSET_W - 2;
  localparam int LINE_W = 8 * LINE_BYTES;
  localparam int LADDR_W = ADDR_W - OFFSET_W;
  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, FILL_WAIT} state_t;
  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction
  function automatic logic [INDEX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
    return a[OFFSET_W +: INDEX_W];
  endfunction
  function automatic logic [WORD_SEL_W-1:0] addr_word(input logic [ADDR_W-1:0] a);
    return a[2 +: WORD_SEL_W];
  endfunction
endpackage

// File: rtl/cache_line_store.sv
// cache_line_store: tag/valid/dirty/data arrays with one combinational read port,
// a word-write port (sets dirty) and a line-fill port (valid, clean).
module cache_line_store
  import cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [INDEX_W-1:0]    idx,
  output logic                  rd_valid,
  output logic                  rd_dirty,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [LINE_W-1:0]     rd_line,
  input  logic                  word_we,
  input  logic [WORD_SEL_W-1:0] word_sel,
  input  logic [31:0]           word_data,
  input  logic                  fill_en,
  input  logic [TAG_W-1:0]      fill_tag,
  input  logic [LINE_W-1:0]     fill_line
);
  logic [NUM_SETS-1:0] valid, dirty;
  logic [TAG_W-1:0]    tags  [NUM_SETS];
  logic [LINE_W-1:0]   lines [NUM_SETS];
  assign rd_valid = valid[idx];
  assign rd_dirty = dirty[idx];
  assign rd_tag = tags[idx];
  assign rd_line = lines[idx];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      valid <= '0;
      dirty <= '0;
    end else if (fill_en) begin
      valid[idx] <= 1'b1;
      dirty[idx] <= 1'b0;
    end else if (word_we)
      dirty[idx] <= 1'b1;
  // Payload arrays need no reset: valid bits gate every use.
  always_ff @(posedge clk)
    if (fill_en) begin
      tags[idx] <= fill_tag;
      lines[idx] <= fill_line;
    end else if (word_we)
      lines[idx][{word_sel, 5'b0} +: 32] <= word_data;
endmodule

// File: rtl/data_cache_ctrl.sv
// data_cache_ctrl: direct-mapped write-back/write-allocate data cache controller.
// Define CACHE_STATS_EN to build the hit/miss counters (otherwise they read 0).
module data_cache_ctrl
  import cache_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               is_input_valid,
  input  logic [ADDR_W-1:0]  addr,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [31:0]        din,
  output logic               is_ready,
  output logic               is_output_valid,
  output logic [31:0]        dout,
  output logic               is_hit,
  output logic               mem_is_input_valid,
  output logic [LADDR_W-1:0] mem_addr,
  output logic               mem_req_read,
  output logic               mem_req_write,
  output logic [LINE_W-1:0]  mem_din,
  input  logic               mem_is_ready,
  input  logic               mem_is_output_valid,
  input  logic [LINE_W-1:0]  mem_dout,
  output logic [31:0]        hit_count,
  output logic [31:0]        miss_count
);
  state_t state, next;
  logic rd_valid, rd_dirty, req, word_we, fill_en;
  logic [TAG_W-1:0] rd_tag;
  logic [LINE_W-1:0] rd_line;
  logic [INDEX_W-1:0] idx;
  logic [WORD_SEL_W-1:0] word_sel;
  logic unused_addr;
  assign unused_addr = &{1'b0, addr[1:0]};
  assign idx = addr_idx(addr);
  assign word_sel = addr_word(addr);
  assign req = is_input_valid & (mem_read | mem_write);
  assign is_ready = state == IDLE;
  assign is_hit = is_ready & is_input_valid & rd_valid & (rd_tag == addr_tag(addr));
  assign is_output_valid = is_hit & req;
  // Read+write together is treated as a store, so the load data stays 0.
  assign dout = (is_output_valid & !mem_write) ? rd_line[{word_sel, 5'b0} +: 32] : 32'd0;
  assign word_we = is_output_valid & mem_write;
  assign fill_en = (state == FILL_WAIT) & mem_is_output_valid;
  assign mem_req_write = state == WRITEBACK;
  assign mem_req_read = state == ALLOCATE;
  assign mem_is_input_valid = mem_req_write | mem_req_read;
  assign mem_addr = mem_req_write ? {rd_tag, idx} : mem_req_read ? addr[ADDR_W-1:OFFSET_W] : '0;
  assign mem_din = mem_req_write ? rd_line : '0;
  cache_line_store u_store (
    .clk(clk), .reset(reset), .idx(idx),
    .rd_valid(rd_valid), .rd_dirty(rd_dirty), .rd_tag(rd_tag), .rd_line(rd_line),
    .word_we(word_we), .word_sel(word_sel), .word_data(din),
    .fill_en(fill_en), .fill_tag(addr_tag(addr)), .fill_line(mem_dout)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE:      if (req && !is_hit) next = (rd_valid && rd_dirty) ? WRITEBACK : ALLOCATE;
      WRITEBACK: if (mem_is_ready) next = ALLOCATE;
      ALLOCATE:  if (mem_is_ready) next = FILL_WAIT;
      FILL_WAIT: if (mem_is_output_valid) next = IDLE;
      default:   next = IDLE;
    endcase
  end
`ifdef CACHE_STATS_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      hit_count <= '0;
      miss_count <= '0;
    end else begin
      if (is_output_valid) hit_count <= hit_count + 32'd1;
      if (is_ready && next != IDLE) miss_count <= miss_count + 32'd1;
    end
`else
  assign hit_count = '0;
  assign miss_count = '0;
`endif
endmodule
